// File: rtl/dl_down_timer.sv
// dl_down_timer: loadable down-counting timer with a one-cycle done pulse.
// Optional periodic reload mode is built when DL_TIMER_AUTO_RELOAD_EN is defined.
module dl_down_timer #(
    parameter int NUM_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [NUM_BITS-1:0] ld_val,
    input  logic                en,
    input  logic                abort,
    output logic [NUM_BITS-1:0] q,
    output logic                busy,
    output logic                done
);
    typedef enum logic {IDLE, RUN} state_e;
    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                fire;
    logic [NUM_BITS-1:0] next_period;
`ifdef DL_TIMER_AUTO_RELOAD_EN
    logic [NUM_BITS-1:0] reload_q;
    assign ld_ready    = 1'b1;
    assign next_period = fire ? ld_val : reload_q;
    // Reload register tracks the most recent accepted load value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) reload_q <= '0;
        else if (fire) reload_q <= ld_val;
    end
`else
    assign ld_ready    = (state_q == IDLE);
    assign next_period = '0;
`endif
    assign fire = ld_valid && ld_ready;
    assign q    = cnt_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
    // Next-state logic: a zero next period on expiry drops back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (fire && ld_val != '0) begin
                cnt_d   = ld_val;
                state_d = RUN;
            end else if (fire) begin
                done_d = 1'b1;
            end
        end else if (abort) begin
            cnt_d   = '0;
            state_d = IDLE;
        end else if (en && cnt_q > NUM_BITS'(1)) begin
            cnt_d = cnt_q - NUM_BITS'(1);
        end else if (en) begin
            done_d  = 1'b1;
            cnt_d   = next_period;
            state_d = (next_period != '0) ? RUN : IDLE;
        end
    end
    // State, count and done pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_dl_down_timer.sv
// tb_dl_down_timer: randomized scoreboard bench for dl_down_timer against a remaining-count model.
module tb_dl_down_timer;
    localparam int W = 5;
`ifdef DL_TIMER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ld_valid = 1'b0;
    logic         ld_ready;
    logic [W-1:0] ld_val = '0;
    logic         en = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] q;
    logic         busy;
    logic         done;

    typedef struct {
        int q;
        bit busy;
        bit done;
        bit rdy;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    bit m_run = 0;
    int m_rem = 0;
    int m_reload = 0;

    dl_down_timer #(.NUM_BITS(W)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_val(ld_val), .en(en), .abort(abort), .q(q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (int'(q) != e.q || busy !== e.busy || done !== e.done || ld_ready !== e.rdy) begin
                fails++;
                $display("FAIL cycle%0d outputs: got q=%0d busy=%b done=%b rdy=%b, expected q=%0d busy=%b done=%b rdy=%b",
                         cyc, q, busy, done, ld_ready, e.q, e.busy, e.done, e.rdy);
            end
        end
    end

    // One clock of stimulus; the model predicts the outputs after the next edge.
    task automatic step(input bit lv, input int v, input bit e, input bit ab);
        exp_t x;
        bit   fire;
        int   nxt;
        @(negedge clk);
        ld_valid = lv;
        ld_val   = W'(v);
        en       = e;
        abort    = ab;
        fire   = lv && (m_run ? AUTO : 1'b1);
        x.done = 0;
        if (!m_run) begin
            if (fire && v != 0) begin
                m_rem = v;
                m_run = 1;
            end else if (fire) begin
                x.done = 1;
            end
        end else if (ab) begin
            m_rem = 0;
            m_run = 0;
        end else if (e) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                x.done = 1;
                nxt = AUTO ? (fire ? v : m_reload) : 0;
                m_rem = nxt;
                m_run = (nxt != 0);
            end
        end
        if (AUTO && fire) m_reload = v;
        x.q    = m_rem;
        x.busy = m_run;
        x.rdy  = m_run ? AUTO : 1'b1;
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        exp_t x;
        @(negedge clk);
        ld_valid = 0;
        en = 0;
        abort = 0;
        #1;
        rst = 1;
        #1;
        chk("async_rst_q", int'(q), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_rdy", int'(ld_ready), 1);
        #1;
        rst = 0;
        m_run = 0;
        m_rem = 0;
        m_reload = 0;
        x.q = 0;
        x.busy = 0;
        x.done = 0;
        x.rdy = 1;
        sb.push_back(x);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_rdy", int'(ld_ready), 1);
        @(negedge clk);
        rst = 0;
        // Reset mid-run with q=7.
        step(1, 7, 0, 0);
        step(0, 0, 0, 0);
        async_reset();
        // Load 5 with continuous enable.
        step(1, 5, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        // Load 4 with random enable: done after exactly four enabled edges.
        step(1, 4, 0, 0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            bit e;
            e = 1'($urandom_range(0, 1));
            step(0, 0, e, 0);
            @(posedge clk);
            #2;
            if (e) n++;
            if (done) break;
        end
        chk("en_edges_to_done", n, AUTO ? n : 4);
        if (!AUTO) chk("done_seen_len4", int'(done), 1);
        step(0, 0, 0, 1);
        // Zero-length timer.
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // Abort at q=6 with en high, then a normal load of 3.
        step(1, 9, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(1, 3, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        // Max load, no wrap.
        step(1, 31, 0, 0);
        for (int i = 0; i < 32; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
`ifdef DL_TIMER_AUTO_RELOAD_EN
        step(1, 3, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
        step(1, 2, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
`endif
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 31),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) async_reset();
        end
        step(0, 0, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
